// File: rtl/chart_sequencer_if.sv
// rtl/chart_sequencer_if.sv - chart load, song time, control and note output bus of the chart sequencer
interface chart_sequencer_if #(
    parameter int NUM_TRACKS = 4,
    parameter int NOTE_COUNT = 256,
    parameter int TIME_W     = 32,
    parameter int PITCH_W    = 32
);
    localparam int AW = $clog2(NOTE_COUNT);

    logic [TIME_W-1:0]     i_cur_time;
    logic                  i_ld_we;
    logic [AW-1:0]         i_ld_addr;
    logic [TIME_W-1:0]     i_ld_time;
    logic [NUM_TRACKS-1:0] i_ld_mask;
    logic [PITCH_W-1:0]    i_ld_pitch;
    logic [AW:0]           i_len;
    logic                  i_start;
    logic                  i_pause;
    logic [NUM_TRACKS-1:0] o_note;
    logic [PITCH_W-1:0]    o_gen_pitch;
    logic                  o_note_valid;
    logic                  o_game_end;
    logic                  o_busy;
    logic [AW:0]           o_notes_left;

    modport master (
        output i_cur_time, i_ld_we, i_ld_addr, i_ld_time, i_ld_mask, i_ld_pitch,
               i_len, i_start, i_pause,
        input  o_note, o_gen_pitch, o_note_valid, o_game_end, o_busy, o_notes_left
    );

    modport slave (
        input  i_cur_time, i_ld_we, i_ld_addr, i_ld_time, i_ld_mask, i_ld_pitch,
               i_len, i_start, i_pause,
        output o_note, o_gen_pitch, o_note_valid, o_game_end, o_busy, o_notes_left
    );
endinterface

// File: rtl/chart_sequencer.sv
// rtl/chart_sequencer.sv - rhythm chart sequencer emitting timed lane pulses from a chart RAM
module chart_sequencer #(
    parameter int NUM_TRACKS = 4,
    parameter int NOTE_COUNT = 256,
    parameter int TIME_W     = 32,
    parameter int PITCH_W    = 32,
    parameter int LEAD_MS    = 0,
    parameter int END_DELAY  = 5000
) (
    input  logic             clk,
    input  logic             rst,
    chart_sequencer_if.slave bus
);
    localparam int AW  = $clog2(NOTE_COUNT);
    localparam int TW1 = TIME_W + 1;
    localparam logic [AW:0] LEN_MAX = (AW+1)'(NOTE_COUNT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t state;
    state_t state_nx;

    // chart storage; deliberately not reset so a chart survives resets and replays
    logic [TIME_W-1:0]     mem_time  [NOTE_COUNT];
    logic [NUM_TRACKS-1:0] mem_mask  [NOTE_COUNT];
    logic [PITCH_W-1:0]    mem_pitch [NOTE_COUNT];

    logic [AW-1:0]         idx;
    logic [AW:0]           notes_left;
    logic [TW1-1:0]        last_time;
    logic [NUM_TRACKS-1:0] note_q;
    logic                  note_valid_q;
    logic [PITCH_W-1:0]    pitch_q;

    logic                  len_ok;
    logic                  start_go;
    logic                  emit;
    logic                  end_hit;
    logic                  busy;
    logic                  game_end;
    logic [TW1-1:0]        now_time;
    logic [TW1-1:0]        lead_time;
    logic [TW1-1:0]        entry_time;
    logic [TW1-1:0]        end_time;

    // all time arithmetic carries one extra bit so large timestamps cannot wrap
    assign len_ok     = (bus.i_len != '0) && (bus.i_len <= LEN_MAX);
    assign now_time   = {1'b0, bus.i_cur_time};
    assign lead_time  = now_time + TW1'(LEAD_MS);
    assign entry_time = {1'b0, mem_time[idx]};
    assign end_time   = last_time + TW1'(END_DELAY);

    // chart loading is only accepted while idle
    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.i_ld_we) begin
            mem_time[bus.i_ld_addr]  <= bus.i_ld_time;
            mem_mask[bus.i_ld_addr]  <= bus.i_ld_mask;
            mem_pitch[bus.i_ld_addr] <= bus.i_ld_pitch;
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state logic; pause takes priority over emission and song end
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.i_start && len_ok) state_nx = S_RUN;
            S_RUN: begin
                if (bus.i_pause)  state_nx = S_PAUSE;
                else if (end_hit) state_nx = S_DONE;
            end
            S_PAUSE: if (!bus.i_pause) state_nx = S_RUN;
            S_DONE:  if (bus.i_start) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // per-state decode of the emission, end and status conditions
    always_comb begin
        start_go = 1'b0;
        emit     = 1'b0;
        end_hit  = 1'b0;
        busy     = 1'b0;
        game_end = 1'b0;
        case (state)
            S_IDLE:  start_go = bus.i_start && len_ok;
            S_RUN: begin
                busy    = 1'b1;
                emit    = !bus.i_pause && (notes_left != '0) && (lead_time >= entry_time);
                end_hit = (notes_left == '0) && (now_time >= end_time);
            end
            S_PAUSE: busy = 1'b1;
            S_DONE:  game_end = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // song position and registered note outputs; pulses last a single cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx          <= '0;
            notes_left   <= '0;
            last_time    <= '0;
            note_q       <= '0;
            note_valid_q <= 1'b0;
            pitch_q      <= '0;
        end else begin
            note_q       <= '0;
            note_valid_q <= 1'b0;
            if (start_go) begin
                idx        <= '0;
                notes_left <= bus.i_len;
            end else if (emit) begin
                note_q       <= mem_mask[idx];
                note_valid_q <= |mem_mask[idx];
                pitch_q      <= mem_pitch[idx];
                idx          <= idx + AW'(1);
                notes_left   <= notes_left - (AW+1)'(1);
                // the final entry's time is the base of the end-of-song timeout
                if (notes_left == (AW+1)'(1)) last_time <= entry_time;
            end
        end
    end

    assign bus.o_note       = note_q;
    assign bus.o_note_valid = note_valid_q;
    assign bus.o_gen_pitch  = pitch_q;
    assign bus.o_game_end   = game_end;
    assign bus.o_busy       = busy;
    assign bus.o_notes_left = notes_left;
endmodule
